// File: rtl/nmos_sched_pkg.sv
// Shared state encoding and parameter helpers for the two-phase clock-enable scheduler.
package nmos_sched_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPh1  = 3'd1,
        StGap1 = 3'd2,
        StPh2  = 3'd3,
        StGap2 = 3'd4
    } phase_state_e;

    function automatic bit phase_len_ok(input int unsigned len);
        return len >= 1;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/nmos_rst_stretch.sv
// Cell-reset stretcher: holds R high for a whole number of executed phase cycles after
// rst or soft_rst.
module nmos_rst_stretch
    import nmos_sched_pkg::*;
#(
    parameter int unsigned RST_CYC = 4
) (
    input  logic main_clk,
    input  logic rst,
    input  logic soft_rst,
    input  logic cyc_end,
    output logic R
);

    localparam int unsigned LeftW = $clog2(RST_CYC + 1);
    localparam logic [LeftW-1:0] LeftInit = LeftW'(RST_CYC);

    if (!phase_len_ok(RST_CYC)) begin : g_param_check
        $error("nmos_rst_stretch: RST_CYC must be >= 1");
    end

    logic [LeftW-1:0] rst_left_q, rst_left_d;

    // Reload has priority so a soft_rst landing on cyc_end still yields a full stretch.
    always_comb begin
        rst_left_d = rst_left_q;
        if (soft_rst) begin
            rst_left_d = LeftInit;
        end else if (cyc_end && (rst_left_q != '0)) begin
            rst_left_d = rst_left_q - 1'b1;
        end
    end

    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            rst_left_q <= LeftInit;
        end else begin
            rst_left_q <= rst_left_d;
        end
    end

    assign R = (rst_left_q != '0);

endmodule

// File: rtl/nmos_phase_sched.sv
// Two-phase non-overlapping C1/C2 enable scheduler with run/step control, reset stretch
// and a completed-phase-cycle counter.
module nmos_phase_sched
    import nmos_sched_pkg::*;
#(
    parameter int unsigned PH1_LEN = 2,
    parameter int unsigned PH2_LEN = 2,
    parameter int unsigned GAP_LEN = 1,
    parameter int unsigned RST_CYC = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             main_clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             soft_rst,
    output logic             C1,
    output logic             C2,
    output logic             R,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic             cyc_end,
    output logic             busy
);

    localparam int unsigned MaxLen = max3(PH1_LEN, PH2_LEN, GAP_LEN);
    localparam int unsigned LenW   = $clog2(MaxLen) + 1;

    localparam logic [LenW-1:0] Ph1Last = LenW'(PH1_LEN - 1);
    localparam logic [LenW-1:0] Ph2Last = LenW'(PH2_LEN - 1);
    localparam logic [LenW-1:0] GapLast = LenW'(GAP_LEN - 1);

    if (!phase_len_ok(PH1_LEN) || !phase_len_ok(PH2_LEN) || !phase_len_ok(GAP_LEN) ||
        !phase_len_ok(CNT_W)) begin : g_param_check
        $error("nmos_phase_sched: PH1_LEN, PH2_LEN, GAP_LEN and CNT_W must be >= 1");
    end

    phase_state_e     state_q, state_d;
    logic [LenW-1:0]  len_cnt_q, len_cnt_d;
    logic             phase_last;
    logic [CNT_W-1:0] cyc_cnt_q;

    // State register
    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            len_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            len_cnt_q <= len_cnt_d;
        end
    end

    always_comb begin
        phase_last = 1'b0;
        unique case (state_q)
            StPh1:          phase_last = (len_cnt_q == Ph1Last);
            StPh2:          phase_last = (len_cnt_q == Ph2Last);
            StGap1, StGap2: phase_last = (len_cnt_q == GapLast);
            default:        phase_last = 1'b0;
        endcase
    end

    // Next state: run/step are only looked at in IDLE and on the final GAP2 cycle,
    // so a phase is never cut short.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (run || step) state_d = StPh1;
            StPh1:   if (phase_last) state_d = StGap1;
            StGap1:  if (phase_last) state_d = StPh2;
            StPh2:   if (phase_last) state_d = StGap2;
            StGap2:  if (phase_last) state_d = run ? StPh1 : StIdle;
            default: state_d = StIdle;
        endcase

        len_cnt_d = '0;
        if ((state_q != StIdle) && !phase_last) begin
            len_cnt_d = len_cnt_q + 1'b1;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        C1      = (state_q == StPh1);
        C2      = (state_q == StPh2);
        busy    = (state_q != StIdle);
        cyc_end = (state_q == StGap2) && phase_last;
    end

    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            cyc_cnt_q <= '0;
        end else if (soft_rst) begin
            cyc_cnt_q <= '0;
        end else if (cyc_end && !R) begin
            cyc_cnt_q <= cyc_cnt_q + 1'b1;
        end
    end

    assign cyc_cnt = cyc_cnt_q;

    nmos_rst_stretch #(
        .RST_CYC(RST_CYC)
    ) u_rst_stretch (
        .main_clk(main_clk),
        .rst     (rst),
        .soft_rst(soft_rst),
        .cyc_end (cyc_end),
        .R       (R)
    );

endmodule
